xcorr_sequencer: RTL
====================

// Module: xcorr_sequencer
// PURPOSE
//  Sequences the TDOA cross-correlation over two mic sample Buffers (A, B) once both report start_calc.
//  Sweeps lag L from -MAX_LAG to +MAX_LAG, drives both buffers' read_offset, and MACs WINDOW products per lag.
//  Tracks the lag with the maximum correlation score, then hands the result to the aim logic via a valid/ready handshake.
//  Pulses finished_calc and restart back to the buffers so they resume capture.
// PARAMETERS
//  DATA_W   18   sample width, signed two's complement (matches Buffer data_out)
//  ADDR_W   9    buffer read_offset width (512-deep buffers)
//  WINDOW   256  products summed per lag; power of 2
//  MAX_LAG  32   lag sweep bound; WINDOW+2*MAX_LAG <= 2**ADDR_W
//  LAG_W    $clog2(MAX_LAG)+2   signed lag width (7 at defaults)
//  ACC_W    2*DATA_W+$clog2(WINDOW)   accumulator/score width (44 at defaults)
// PORTS
//  clock          in   1       single clock; all logic on posedge
//  reset          in   1       synchronous, active-high
//  start_calc_a   in   1       Buffer A window ready (pulse or level; sampled in IDLE/WAIT only)
//  start_calc_b   in   1       Buffer B window ready
//  data_a         in   DATA_W  Buffer A data_out, valid 1 cycle after read_offset_a
//  data_b         in   DATA_W  Buffer B data_out, valid 1 cycle after read_offset_b
//  read_offset_a  out  ADDR_W  Buffer A read address
//  read_offset_b  out  ADDR_W  Buffer B read address
//  finished_calc  out  1       1-cycle pulse to both buffers on entry to DONE
//  restart        out  1       1-cycle pulse to both buffers after result accepted
//  result_valid   out  1       best_lag/best_score valid; held until accepted
//  result_ready   in   1       consumer accepts when result_valid & result_ready
//  best_lag       out  LAG_W   signed lag of max score (positive = B lags A)
//  best_score     out  ACC_W   signed max score
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; seen_a/seen_b, accumulator, best regs cleared. Reset mid-sweep aborts, no pulses.
//  States: IDLE -> WAIT -> SWEEP -> DRAIN -> CMP -> (SWEEP | DONE) -> IDLE.
//  IDLE/WAIT: latch seen_a|=start_calc_a, seen_b|=start_calc_b; the edge where both are set (incl. same cycle) enters SWEEP
//   with L=-MAX_LAG, i=0, acc=0. IDLE->WAIT once either is seen. Starts outside IDLE/WAIT are ignored.
//  SWEEP (WINDOW cycles): read_offset_a=MAX_LAG+i, read_offset_b=MAX_LAG+i+L; i++ each cycle. Addresses always
//   stay within 0..WINDOW+2*MAX_LAG-1.
//  Pipeline: addr@t -> data@t+1 -> product reg (signed DATA_W x DATA_W) @t+2 -> acc += sext(product) @t+3.
//  DRAIN: 3 cycles, no new addresses (offsets held at last value); the last product lands in acc.
//  CMP (1 cycle): if first lag or acc > best_score (strictly signed greater): best_score=acc, best_lag=L.
//   Ties keep the earlier (more negative) lag. Then if L==+MAX_LAG -> DONE, else L++, i=0, acc=0 -> SWEEP.
//  Timing: each lag takes WINDOW+4 cycles. result_valid first reads high (2*MAX_LAG+1)*(WINDOW+4) cycles after the
//   edge that entered SWEEP (16900 at defaults).
//  DONE: finished_calc=1 on the first DONE cycle only. result_valid=1 with best_* stable until result_valid&result_ready.
//   On that accept edge: result_valid=0 and restart=1 for exactly one cycle. state=IDLE, seen_* cleared.
//   A start_calc seen on the restart cycle is latched.
//  No overflow possible: ACC_W covers WINDOW full-scale products.
// TESTING
//  (Small variant WINDOW=16, MAX_LAG=4 for T1-T5; defaults for T6.)
//  T1 A=B=ramp 1..N, both starts same cycle -> best_lag=0; result_valid exactly (9*20) cycles later; finished_calc 1 pulse.
//  T2 B[n]=A[n-3], A pseudo-random -> best_lag=+3; B[n]=A[n+2] -> best_lag=-2.
//  T3 A=B=constant 100 (all scores equal) -> best_lag=-4 (tie rule); best_score=16*100*100=160000.
//  T4 start_calc_a only, hold 50 cycles -> stays WAIT, read offsets 0, no finished_calc; start_calc_b 1 cycle -> sweep begins next edge.
//  T5 result_ready=0 for 10 cycles after valid -> outputs held, no restart; ready=1 -> restart 1 cycle, then IDLE.
//  T6 Reset asserted mid-SWEEP at lag 0 -> next cycle all outputs 0, IDLE; new start pair -> full correct sweep.

Source files
------------

// File: rtl/xcorr_sequencer.sv
// Sweeps lags -MAX_LAG..+MAX_LAG over two sample buffers. Each lag MACs WINDOW products and keeps the best-scoring lag.
// The winning lag and score are held on a valid/ready handshake. After acceptance, a restart pulse is sent to the buffers.
module xcorr_sequencer #(
  parameter int DATA_W  = 18,
  parameter int ADDR_W  = 9,
  parameter int WINDOW  = 256,
  parameter int MAX_LAG = 32,
  parameter int LAG_W   = $clog2(MAX_LAG) + 2,
  parameter int ACC_W   = 2 * DATA_W + $clog2(WINDOW)
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_start_calc_a,
  input  logic                     i_start_calc_b,
  input  logic signed [DATA_W-1:0] i_data_a,
  input  logic signed [DATA_W-1:0] i_data_b,
  output logic        [ADDR_W-1:0] o_read_offset_a,
  output logic        [ADDR_W-1:0] o_read_offset_b,
  output logic                     o_finished_calc,
  output logic                     o_restart,
  output logic                     o_result_valid,
  input  logic                     i_result_ready,
  output logic signed [LAG_W-1:0]  o_best_lag,
  output logic signed [ACC_W-1:0]  o_best_score
);

  localparam int IDX_W  = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int PROD_W = 2 * DATA_W;
  localparam logic [IDX_W-1:0]        IDX_LAST = IDX_W'(WINDOW - 1);
  localparam logic signed [LAG_W-1:0] LAG_MIN  = LAG_W'(-MAX_LAG);
  localparam logic signed [LAG_W-1:0] LAG_MAX  = LAG_W'(MAX_LAG);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_SWEEP,
    S_DRAIN,
    S_CMP,
    S_DONE
  } state_t;

  state_t                    r_state;
  state_t                    w_state_next;
  logic                      r_seen_a;
  logic                      r_seen_b;
  logic signed [LAG_W-1:0]   r_lag;
  logic        [IDX_W-1:0]   r_idx;
  logic        [1:0]         r_drain;
  logic        [ADDR_W-1:0]  r_rd_a;
  logic        [ADDR_W-1:0]  r_rd_b;
  logic                      r_dvalid;
  logic                      r_pvalid;
  logic signed [PROD_W-1:0]  r_prod;
  logic signed [ACC_W-1:0]   r_acc;
  logic signed [LAG_W-1:0]   r_best_lag;
  logic signed [ACC_W-1:0]   r_best_score;
  logic                      r_finished;
  logic                      r_restart;

  logic                      w_seen_a;
  logic                      w_seen_b;
  logic                      w_start;
  logic                      w_next_lag;
  logic                      w_cmp_take;
  logic                      w_enter_done;
  logic                      w_accept;
  logic signed [LAG_W-1:0]   w_lag_load;
  logic        [ADDR_W-1:0]  w_base_b;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_next_lag   = 1'b0;
    w_cmp_take   = 1'b0;
    w_enter_done = 1'b0;
    w_accept     = 1'b0;
    w_seen_a     = r_seen_a | i_start_calc_a;
    w_seen_b     = r_seen_b | i_start_calc_b;
    case (r_state)
      S_IDLE, S_WAIT: begin
        if (w_seen_a && w_seen_b) begin
          w_state_next = S_SWEEP;
          w_start      = 1'b1;
        end else if (w_seen_a || w_seen_b) begin
          w_state_next = S_WAIT;
        end
      end
      S_SWEEP: begin
        if (r_idx == IDX_LAST) w_state_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (r_drain == 2'd2) w_state_next = S_CMP;
      end
      S_CMP: begin
        // Strict greater-than keeps the earliest (most negative) lag on ties.
        w_cmp_take = (r_lag == LAG_MIN) || (r_acc > r_best_score);
        if (r_lag == LAG_MAX) begin
          w_state_next = S_DONE;
          w_enter_done = 1'b1;
        end else begin
          w_state_next = S_SWEEP;
          w_next_lag   = 1'b1;
        end
      end
      S_DONE: begin
        if (i_result_ready) begin
          w_state_next = S_IDLE;
          w_accept     = 1'b1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign w_lag_load = w_start ? LAG_MIN : (r_lag + LAG_W'(1));
  assign w_base_b   = ADDR_W'(MAX_LAG + int'(w_lag_load));

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_seen_a     <= 1'b0;
      r_seen_b     <= 1'b0;
      r_lag        <= '0;
      r_idx        <= '0;
      r_drain      <= '0;
      r_rd_a       <= '0;
      r_rd_b       <= '0;
      r_dvalid     <= 1'b0;
      r_pvalid     <= 1'b0;
      r_prod       <= '0;
      r_acc        <= '0;
      r_best_lag   <= '0;
      r_best_score <= '0;
      r_finished   <= 1'b0;
      r_restart    <= 1'b0;
    end else begin
      if (w_start || w_accept) begin
        r_seen_a <= 1'b0;
        r_seen_b <= 1'b0;
      end else if (r_state == S_IDLE || r_state == S_WAIT) begin
        r_seen_a <= w_seen_a;
        r_seen_b <= w_seen_b;
      end

      if (w_start || w_next_lag) begin
        r_lag  <= w_lag_load;
        r_idx  <= '0;
        r_acc  <= '0;
        r_rd_a <= ADDR_W'(MAX_LAG);
        r_rd_b <= w_base_b;
      end else begin
        if (r_state == S_SWEEP && r_idx != IDX_LAST) begin
          r_idx  <= r_idx + IDX_W'(1);
          r_rd_a <= r_rd_a + ADDR_W'(1);
          r_rd_b <= r_rd_b + ADDR_W'(1);
        end else if (w_accept) begin
          r_rd_a <= '0;
          r_rd_b <= '0;
        end
        if (r_pvalid) begin
          r_acc <= r_acc + {{(ACC_W - PROD_W){r_prod[PROD_W-1]}}, r_prod};
        end
      end

      // Buffer data arrives one cycle after its address; product is registered before accumulation.
      r_dvalid <= (r_state == S_SWEEP);
      r_pvalid <= r_dvalid;
      if (r_dvalid) r_prod <= i_data_a * i_data_b;

      r_drain <= (r_state == S_DRAIN) ? r_drain + 2'd1 : 2'd0;

      if (w_cmp_take) begin
        r_best_score <= r_acc;
        r_best_lag   <= r_lag;
      end

      r_finished <= w_enter_done;
      r_restart  <= w_accept;
    end
  end

  assign o_read_offset_a = r_rd_a;
  assign o_read_offset_b = r_rd_b;
  assign o_finished_calc = r_finished;
  assign o_restart       = r_restart;
  assign o_result_valid  = (r_state == S_DONE);
  assign o_best_lag      = r_best_lag;
  assign o_best_score    = r_best_score;

endmodule
